// File: rtl/reg_file_ctrl_pkg.sv
// Shared constants for reg_file_ctrl: opcodes, FSM state encoding and instruction field positions.
package reg_file_ctrl_pkg;

    localparam int FIELD_W    = 8;
    localparam int OPCODE_LSB = 24;
    localparam int DEST_LSB   = 16;
    localparam int SRC1_LSB   = 8;
    localparam int SRC2_LSB   = 0;

    typedef logic [FIELD_W-1:0] opcode_t;

    localparam opcode_t OP_LOADI = 8'h00;
    localparam opcode_t OP_MOV   = 8'h01;
    localparam opcode_t OP_ADD   = 8'h02;
    localparam opcode_t OP_SUB   = 8'h03;
    localparam opcode_t OP_AND   = 8'h04;
    localparam opcode_t OP_OR    = 8'h05;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_DECODE = 3'd1;
    localparam state_t ST_READ   = 3'd2;
    localparam state_t ST_EXEC   = 3'd3;
    localparam state_t ST_WB     = 3'd4;

    function automatic logic [FIELD_W-1:0] get_field(input logic [31:0] instr, input int lsb);
        return instr[lsb +: FIELD_W];
    endfunction

endpackage

// File: rtl/reg_file_ctrl_if.sv
// Instruction handshake plus reg_file port bundle; master is the controller, slave is its environment.
// ILLEGAL exists only when REG_FILE_CTRL_ILLEGAL_TRAP_EN is defined.
interface reg_file_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic [31:0]       INSTR;
    logic              INSTR_VALID;
    logic              INSTR_READY;
    logic [ADDR_W-1:0] READREG1;
    logic [ADDR_W-1:0] READREG2;
    logic [DATA_W-1:0] REGOUT1;
    logic [DATA_W-1:0] REGOUT2;
    logic [ADDR_W-1:0] WRITEREG;
    logic [DATA_W-1:0] WRITEDATA;
    logic              WRITEENABLE;
    logic              DONE;

`ifdef REG_FILE_CTRL_ILLEGAL_TRAP_EN
    logic              ILLEGAL;

    modport master (
        input  INSTR, INSTR_VALID, REGOUT1, REGOUT2,
        output INSTR_READY, READREG1, READREG2, WRITEREG, WRITEDATA, WRITEENABLE, DONE, ILLEGAL
    );

    modport slave (
        output INSTR, INSTR_VALID, REGOUT1, REGOUT2,
        input  INSTR_READY, READREG1, READREG2, WRITEREG, WRITEDATA, WRITEENABLE, DONE, ILLEGAL
    );
`else
    modport master (
        input  INSTR, INSTR_VALID, REGOUT1, REGOUT2,
        output INSTR_READY, READREG1, READREG2, WRITEREG, WRITEDATA, WRITEENABLE, DONE
    );

    modport slave (
        output INSTR, INSTR_VALID, REGOUT1, REGOUT2,
        input  INSTR_READY, READREG1, READREG2, WRITEREG, WRITEDATA, WRITEENABLE, DONE
    );
`endif

endinterface

// File: rtl/reg_file_ctrl_alu.sv
// Combinational result unit for reg_file_ctrl; all arithmetic wraps modulo 2^DATA_W.
module reg_file_ctrl_alu
    import reg_file_ctrl_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  opcode_t           opcode,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              illegal
);

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (opcode)
            OP_LOADI: result = imm;
            OP_MOV:   result = b;
            OP_ADD:   result = a + b;
            OP_SUB:   result = a - b;
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/reg_file_ctrl.sv
// reg_file_ctrl: one-instruction-at-a-time read-modify-write sequencer owning every reg_file port.
// Optional feature macro: REG_FILE_CTRL_ILLEGAL_TRAP_EN adds a sticky ILLEGAL output.
module reg_file_ctrl
    import reg_file_ctrl_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 3,
    parameter int READ_WAIT = 1
) (
    input logic             CLK,
    input logic             RESET,
    reg_file_ctrl_if.master bus
);

    localparam int               CNT_W     = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(READ_WAIT - 1);

    state_t            state;
    logic [31:0]       instr_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic              out_of_reset;
    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              write_enable;
    logic              done;
    logic              accept;
    opcode_t           opcode;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] alu_result;
    logic              alu_illegal;
    logic              unused_fields;

    assign opcode = get_field(instr_q, OPCODE_LSB);
    assign imm    = DATA_W'(get_field(instr_q, SRC2_LSB));

    // Only the low ADDR_W bits of DEST/SRC1 matter; the rest are deliberately dropped.
    assign unused_fields = ^{instr_q[DEST_LSB +: FIELD_W], instr_q[SRC1_LSB +: FIELD_W]};

    // Ready stays low through reset and rises on the first edge after release.
    assign bus.INSTR_READY = (state == ST_IDLE) && out_of_reset;
    assign accept          = bus.INSTR_READY && bus.INSTR_VALID;

    reg_file_ctrl_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .opcode  (opcode),
        .imm     (imm),
        .a       (bus.REGOUT1),
        .b       (bus.REGOUT2),
        .result  (alu_result),
        .illegal (alu_illegal)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state        <= ST_IDLE;
            instr_q      <= '0;
            wait_cnt     <= '0;
            out_of_reset <= 1'b0;
            read_reg1    <= '0;
            read_reg2    <= '0;
            write_reg    <= '0;
            write_data   <= '0;
            write_enable <= 1'b0;
            done         <= 1'b0;
        end else begin
            out_of_reset <= 1'b1;
            write_enable <= 1'b0;
            done         <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        instr_q <= bus.INSTR;
                        state   <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    read_reg1 <= ADDR_W'(get_field(instr_q, SRC1_LSB));
                    read_reg2 <= ADDR_W'(get_field(instr_q, SRC2_LSB));
                    wait_cnt  <= '0;
                    state     <= ST_READ;
                end
                ST_READ: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= ST_EXEC;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_EXEC: begin
                    done  <= 1'b1;
                    state <= ST_WB;
                    // Write target/data move only here, so reg_file sees them stable between writes.
                    if (!alu_illegal) begin
                        write_enable <= 1'b1;
                        write_reg    <= ADDR_W'(get_field(instr_q, DEST_LSB));
                        write_data   <= alu_result;
                    end
                end
                ST_WB: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.READREG1    = read_reg1;
    assign bus.READREG2    = read_reg2;
    assign bus.WRITEREG    = write_reg;
    assign bus.WRITEDATA   = write_data;
    assign bus.WRITEENABLE = write_enable;
    assign bus.DONE        = done;

`ifdef REG_FILE_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            illegal_q <= 1'b0;
        end else if ((state == ST_EXEC) && alu_illegal) begin
            illegal_q <= 1'b1;
        end
    end

    assign bus.ILLEGAL = illegal_q;
`endif

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Self-checking bench for reg_file_ctrl: directed vector table, corner sequences, randomized traffic
// against an instruction-level model. Honours REG_FILE_CTRL_ILLEGAL_TRAP_EN for the ILLEGAL checks.
module tb_reg_file_ctrl;

    logic CLK = 1'b0;
    logic RESET;
    logic rf_clear;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    reg_file_ctrl_if #(.DATA_W(8), .ADDR_W(3)) bus ();

    reg_file_ctrl #(
        .DATA_W    (8),
        .ADDR_W    (3),
        .READ_WAIT (1)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    // Environment register file: combinational reads, write on the edge leaving WB.
    logic [7:0] rf [8];

    always @(posedge CLK) begin
        if (rf_clear) begin
            for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
        end else if (bus.WRITEENABLE) begin
            rf[bus.WRITEREG] <= bus.WRITEDATA;
        end
    end

    assign bus.REGOUT1 = rf[bus.READREG1];
    assign bus.REGOUT2 = rf[bus.READREG2];

    // Instruction-level reference model.
    logic [7:0] ref_rf [8];
    logic       ref_illegal;
    logic [2:0] last_wreg;
    logic [7:0] last_wdata;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [7:0]  exp_val;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic run_instr(input logic [31:0] ins, input string tag);
        int         waited;
        logic [7:0] op;
        logic [2:0] d;
        logic [2:0] s1;
        logic [2:0] s2;
        logic [7:0] res;
        logic       legal;
        logic [3:0] we_seen;
        logic [3:0] done_seen;
        logic [3:0] rdy_seen;
        waited = 0;
        while (!bus.INSTR_READY && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        check({tag, "_ready_wait"}, 32'(bus.INSTR_READY), 32'd1);
        if (!bus.INSTR_READY) return;

        op = ins[31:24];
        d  = ins[18:16];
        s1 = ins[10:8];
        s2 = ins[2:0];
        legal = 1'b1;
        res   = 8'h00;
        case (op)
            8'h00:   res = ins[7:0];
            8'h01:   res = ref_rf[s2];
            8'h02:   res = 8'((int'(ref_rf[s1]) + int'(ref_rf[s2])) % 256);
            8'h03:   res = 8'((int'(ref_rf[s1]) - int'(ref_rf[s2]) + 256) % 256);
            8'h04:   res = ref_rf[s1] & ref_rf[s2];
            8'h05:   res = ref_rf[s1] | ref_rf[s2];
            default: legal = 1'b0;
        endcase

        bus.INSTR       = ins;
        bus.INSTR_VALID = 1'b1;
        @(posedge CLK);
        #1;
        bus.INSTR_VALID = 1'b0;
        bus.INSTR       = $urandom;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            we_seen[k]   = bus.WRITEENABLE;
            done_seen[k] = bus.DONE;
            rdy_seen[k]  = bus.INSTR_READY;
            if (k == 3) begin
                check({tag, "_writereg"},  32'(bus.WRITEREG),  legal ? 32'(d)   : 32'(last_wreg));
                check({tag, "_writedata"}, 32'(bus.WRITEDATA), legal ? 32'(res) : 32'(last_wdata));
            end
        end
        check({tag, "_we_pattern"},   32'(we_seen),   legal ? 32'h8 : 32'h0);
        check({tag, "_done_pattern"}, 32'(done_seen), 32'h8);
        check({tag, "_ready_busy"},   32'(rdy_seen),  32'h0);

        if (legal) begin
            ref_rf[d]  = res;
            last_wreg  = d;
            last_wdata = res;
        end else begin
            ref_illegal = 1'b1;
        end

        @(posedge CLK);
        #1;
        check({tag, "_ready_after"}, 32'(bus.INSTR_READY), 32'd1);
        check({tag, "_rf_dest"},     32'(rf[d]),           32'(ref_rf[d]));
`ifdef REG_FILE_CTRL_ILLEGAL_TRAP_EN
        check({tag, "_illegal"},     32'(bus.ILLEGAL),     32'(ref_illegal));
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hs [3];
        int          idx;
        int          n_done;
        int          last_done;
        int          gap_bad;
        int          rdy_bad;
        int          since;
        logic        rdy_pre;
        int          r;
        logic [7:0]  op;
        logic [31:0] ins;

        vecs[0]  = '{"loadi_r3_56",   32'h00_03_00_38, 8'd56};
        vecs[1]  = '{"mov_r5_r3",     32'h01_05_00_03, 8'd56};
        vecs[2]  = '{"loadi_r1_200",  32'h00_01_00_C8, 8'd200};
        vecs[3]  = '{"loadi_r2_100",  32'h00_02_00_64, 8'd100};
        vecs[4]  = '{"add_wrap_r4",   32'h02_04_01_02, 8'd44};
        vecs[5]  = '{"sub_wrap_r6",   32'h03_06_02_01, 8'd156};
        vecs[6]  = '{"and_hibits_r7", 32'h04_F7_09_0A, 8'd64};
        vecs[7]  = '{"or_r0",         32'h05_00_01_02, 8'd236};
        vecs[8]  = '{"loadi_r1_7",    32'h00_01_00_07, 8'd7};
        vecs[9]  = '{"alias_add_1",   32'h02_01_01_01, 8'd14};
        vecs[10] = '{"alias_add_2",   32'h02_01_01_01, 8'd28};
        vecs[11] = '{"illegal_09",    32'h09_02_01_01, 8'd100};
        vecs[12] = '{"loadi_after",   32'h00_02_00_21, 8'd33};

        for (int i = 0; i < 8; i++) ref_rf[i] = 8'h00;
        ref_illegal = 1'b0;
        last_wreg   = 3'd0;
        last_wdata  = 8'h00;

        // Reset state
        RESET           = 1'b0;
        rf_clear        = 1'b1;
        bus.INSTR       = 32'h0;
        bus.INSTR_VALID = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ready_low", 32'(bus.INSTR_READY), 32'd0);
        check("rst_outputs",   {bus.READREG1, bus.READREG2, bus.WRITEREG, bus.WRITEDATA,
                                bus.WRITEENABLE, bus.DONE}, 32'd0);
        @(negedge CLK);
        RESET    = 1'b1;
        rf_clear = 1'b0;
        @(posedge CLK);
        #1;
        check("rst_release_ready", 32'(bus.INSTR_READY), 32'd1);

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            run_instr(vecs[i].instr, vecs[i].name);
            check({vecs[i].name, "_table"}, 32'(rf[vecs[i].instr[18:16]]), 32'(vecs[i].exp_val));
        end

        // Reset asserted in the middle of WB of an add to r3
        bus.INSTR       = 32'h02_03_01_02;
        bus.INSTR_VALID = 1'b1;
        @(posedge CLK);
        #1;
        bus.INSTR_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("midwb_we_high", 32'(bus.WRITEENABLE), 32'd1);
        #1;
        RESET = 1'b0;
        #1;
        check("midwb_we_drop",   32'(bus.WRITEENABLE), 32'd0);
        check("midwb_done_drop", 32'(bus.DONE),        32'd0);
        check("midwb_ready_low", 32'(bus.INSTR_READY), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        check("midwb_r3_kept", 32'(rf[3]), 32'd56);
        @(negedge CLK);
        RESET       = 1'b1;
        ref_illegal = 1'b0;
        last_wreg   = 3'd0;
        last_wdata  = 8'h00;
        @(posedge CLK);
        #1;
        check("midwb_ready_after", 32'(bus.INSTR_READY), 32'd1);
        check("midwb_outputs_zero", {bus.READREG1, bus.READREG2, bus.WRITEREG, bus.WRITEDATA,
                                     bus.WRITEENABLE, bus.DONE}, 32'd0);
`ifdef REG_FILE_CTRL_ILLEGAL_TRAP_EN
        check("midwb_illegal_clr", 32'(bus.ILLEGAL), 32'd0);
`endif

        // INSTR_VALID held high across three instructions
        hs[0] = 32'h00_00_00_0B;
        hs[1] = 32'h00_01_00_16;
        hs[2] = 32'h02_02_00_01;
        idx = 0; n_done = 0; last_done = -1; gap_bad = 0; rdy_bad = 0; since = 99;
        @(negedge CLK);
        bus.INSTR       = hs[0];
        bus.INSTR_VALID = 1'b1;
        for (int c = 0; c < 30; c++) begin
            rdy_pre = bus.INSTR_READY;
            @(posedge CLK);
            #1;
            if (rdy_pre && bus.INSTR_VALID) begin
                since = 0;
                idx++;
                if (idx < 3) bus.INSTR = hs[idx];
                else bus.INSTR_VALID = 1'b0;
            end else begin
                since++;
            end
            @(negedge CLK);
            if (bus.DONE) begin
                if (last_done >= 0 && c - last_done != 5) gap_bad++;
                last_done = c;
                n_done++;
            end
            if (bus.INSTR_READY && since < 4) rdy_bad++;
        end
        ref_rf[0] = 8'd11; ref_rf[1] = 8'd22; ref_rf[2] = 8'd33;
        last_wreg = 3'd2;  last_wdata = 8'd33;
        check("hs_accepts",   32'(idx),     32'd3);
        check("hs_done_cnt",  32'(n_done),  32'd3);
        check("hs_done_gap",  32'(gap_bad), 32'd0);
        check("hs_ready_low", 32'(rdy_bad), 32'd0);
        check("hs_r0", 32'(rf[0]), 32'd11);
        check("hs_r1", 32'(rf[1]), 32'd22);
        check("hs_r2", 32'(rf[2]), 32'd33);

        // Randomized traffic against the model
        for (int n = 0; n < 40; n++) begin
            r  = $urandom_range(0, 6);
            op = (r < 6) ? 8'(r) : 8'($urandom_range(6, 255));
            ins = {op, 8'($urandom), 8'($urandom), 8'($urandom)};
            run_instr(ins, $sformatf("rand%0d_op%0h", n, op));
        end
        for (int i = 0; i < 8; i++) begin
            check($sformatf("final_rf%0d", i), 32'(rf[i]), 32'(ref_rf[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_ctrl.md
Name: reg_file_ctrl

Overview:
Instruction sequencer that sits in front of reg_file and owns all of its ports. It performs the full read-modify-write traffic for one instruction at a time.
- Accepts one 32-bit instruction per valid/ready handshake.
- Drives READREG1/READREG2, consumes REGOUT1/REGOUT2, computes the result, and issues a single-cycle write (WRITEREG/WRITEDATA/WRITEENABLE).
- Feeds the ALU/datapath stage of the CPU.

Parameters:
DATA_W, 8, register/data width
ADDR_W, 3, register address width (8 registers)
READ_WAIT, 1, cycles held in READ state to cover reg_file read latency (minimum 1)

Ports:
CLK  input  1  clock, rising-edge
RESET  input  1  asynchronous, active-low reset (0 = reset)
INSTR  input  32  [31:24] OPCODE, [23:16] DEST, [15:8] SRC1, [7:0] SRC2/IMM
INSTR_VALID  input  1  INSTR is valid
INSTR_READY  output  1  controller can accept an instruction
READREG1  output  ADDR_W  reg_file read address 1
READREG2  output  ADDR_W  reg_file read address 2
REGOUT1  input  DATA_W  reg_file read data 1
REGOUT2  input  DATA_W  reg_file read data 2
WRITEREG  output  ADDR_W  reg_file write address
WRITEDATA  output  DATA_W  reg_file write data
WRITEENABLE  output  1  reg_file write strobe
DONE  output  1  one-cycle pulse, instruction retired

Behaviour:
- Reset (asynchronous, RESET=0):
  - state=IDLE.
  - INSTR_READY=0 while RESET=0, then 1 from the first cycle after release.
  - All other outputs 0.
  - WRITEENABLE drops immediately, including when reset asserts mid-instruction.
  - An in-flight instruction is discarded without a write.
- States: IDLE -> DECODE -> READ -> EXEC -> WB -> IDLE.
- IDLE:
  - INSTR_READY=1.
  - On a rising edge with INSTR_VALID=1: capture INSTR and go to DECODE. INSTR_READY is 0 in every other state.
- DECODE (1 cycle): register READREG1=SRC1[ADDR_W-1:0] and READREG2=SRC2[ADDR_W-1:0]; go to READ.
- READ: hold for READ_WAIT cycles; the read addresses stay stable; go to EXEC.
- EXEC (1 cycle): sample REGOUT1/REGOUT2 and register the result into WRITEDATA and DEST[ADDR_W-1:0] into WRITEREG; go to WB.
- WB (1 cycle): WRITEENABLE=1 and DONE=1; the reg_file writes on the rising edge that leaves WB; go to IDLE.
- WRITEREG and WRITEDATA change only on EXEC->WB. Between writes they hold their last value so reg_file's delayed write sampling stays correct.
- Latency with READ_WAIT=1:
  - Accept edge N. WRITEENABLE is high in cycle N+3..N+4 and the write lands at edge N+4.
  - Next accept is possible at edge N+5, so throughput is 1 instruction per 5 cycles.
- Opcodes (all arithmetic mod 2^DATA_W, no flags):
  - 0x00 loadi: result=IMM[DATA_W-1:0]
  - 0x01 mov: result=REGOUT2
  - 0x02 add: REGOUT1+REGOUT2
  - 0x03 sub: REGOUT1-REGOUT2 (two's complement, wraps)
  - 0x04 and
  - 0x05 or
- Every opcode takes the same path and latency; loadi ignores the read data.
- Unused address bits in DEST/SRC1/SRC2 are ignored.
- DEST equal to SRC1 or SRC2: operands are read before the write, so the old value is used.
- INSTR_VALID asserted outside IDLE: ignored. The instruction is not captured, and the source must hold it until INSTR_READY.
- Illegal opcode (>0x05): see Optional Feature.

Optional Feature:
Macro REG_FILE_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - Extra output ILLEGAL (1 bit, reset 0), a sticky flag set in EXEC on an illegal opcode and cleared only by reset.
  - The illegal instruction suppresses WRITEENABLE in WB; DONE still pulses.
- Not defined:
  - No ILLEGAL port.
  - Illegal opcodes retire as NOP: WB is entered with WRITEENABLE=0, DONE=1, and WRITEREG/WRITEDATA unchanged.

Decomposition:
- Package reg_file_ctrl_pkg holds:
  - opcode constants OP_LOADI..OP_OR
  - state encoding typedef (IDLE, DECODE, READ, EXEC, WB)
  - instruction field bit-position constants
- Sub-module reg_file_ctrl_alu: combinational; inputs opcode and two operands, outputs result and an illegal flag.

Test Plan:
- Reset sequencing: RESET=0 mid-WB of an add to reg 3 -> WRITEENABLE drops at once; reg 3 unchanged; after release INSTR_READY=1 and all other outputs 0.
- loadi DEST=3 IMM=56, then mov DEST=5 SRC2=3 -> reg 3=56, then reg 5=56; WRITEENABLE high exactly one cycle each, write at accept edge+4.
- add wrap: reg1=200, reg2=100, add DEST=4 -> reg 4=44; sub reg2-reg1 into 6 -> reg 6=156.
- Operand aliasing: reg1=7, add DEST=1 SRC1=1 SRC2=1 -> reg 1=14; back-to-back second add -> 28.
- Handshake: INSTR_VALID held high continuously with 3 instructions -> exactly 3 DONE pulses, 5 cycles apart; INSTR_READY low outside IDLE; no instruction lost or duplicated.
- Opcode 0x09:
  - with REG_FILE_CTRL_ILLEGAL_TRAP_EN -> ILLEGAL=1, sticky, no write.
  - without the macro -> no write, DONE=1, next instruction executes normally.
